// File: rtl/dataset_ram_if.sv
// Dataset RAM bus interface.
// Groups the write bus, read bus, soft-clear request and status flags of the
// dataset RAM so the loader/compute side and the RAM share one port.
//   master : clr, wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr driven;
//            rd_data, rd_valid, busy, addr_err observed.
//   slave  : the RAM side, directions reversed.
interface dataset_ram_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int LANES      = 16,
    parameter int LENGTH     = 16,
    parameter int DATA_WIDTH = LENGTH * LANES
);
    logic                  clr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [LANES-1:0]      wr_mask;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  busy;
    logic                  addr_err;

    modport master (
        output clr, wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, addr_err
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy, addr_err
    );
endinterface

// File: rtl/dataset_ram.sv
// Dataset RAM: one row per data point, MAX_FEATURES feature lanes plus one
// y lane, each LENGTH bits. Single write port with per-lane mask, single
// registered read port with RD_LATENCY of 1 or 2, hardware clear sequencer
// (runs after reset and on a soft clear) and sticky out-of-range flag.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   RST  - synchronous active-high reset, starts the clear sequence
//   bus  - dataset_ram_if slave: clr, write bus, read bus, busy, addr_err
module dataset_ram #(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = 15,
    parameter int LENGTH       = 16,
    parameter int LANES        = MAX_FEATURES + 1,
    parameter int DATA_WIDTH   = LENGTH * LANES,
    parameter int DEPTH        = 100,
    parameter int RD_LATENCY   = 1
) (
    input  logic            clk,
    input  logic            RST,
    dataset_ram_if.slave    bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic             addr_err_reg;

    logic ready;
    logic wr_in_range;
    logic rd_in_range;
    logic clr_go;
    logic wr_go;
    logic rd_go;
    logic clear_wr;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign ready       = (state_reg == ST_READY);
    assign wr_in_range = (bus.wr_addr <= LAST_ROW);
    assign rd_in_range = (bus.rd_addr <= LAST_ROW);
    // Row indices are only used when the address is in range, so the
    // truncated upper bits never matter.
    assign wr_idx      = bus.wr_addr[IDX_W-1:0];
    assign rd_idx      = bus.rd_addr[IDX_W-1:0];

    assign clr_go   = ready && bus.clr && !RST;
    // A soft clear in the same cycle drops the write but still serves the read.
    assign wr_go    = ready && bus.wr_en && !bus.clr && wr_in_range && !RST;
    assign rd_go    = ready && bus.rd_en && !RST;
    assign clear_wr = !ready && !RST;

    // Clear sequencer: walks every row once, then hands over to READY.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= '0;
        end else if (!ready) begin
            ptr_reg <= ptr_reg + 1'b1;
            if (ptr_reg == LAST_IDX) begin
                state_reg <= ST_READY;
            end
        end else if (clr_go) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= '0;
        end
    end

    // Sticky range error; an accepted soft clear wins over a same-cycle error.
    always_ff @(posedge clk) begin
        if (RST) begin
            addr_err_reg <= 1'b0;
        end else if (clr_go) begin
            addr_err_reg <= 1'b0;
        end else if (ready && ((bus.wr_en && !wr_in_range) ||
                               (bus.rd_en && !rd_in_range))) begin
            addr_err_reg <= 1'b1;
        end
    end

    // Storage is split per lane so the write mask maps onto independent
    // block RAMs; each lane has its own read-first output register.
    logic [DATA_WIDTH-1:0] raw_q;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LENGTH-1:0] lane_mem [0:DEPTH-1];
        logic [LENGTH-1:0] lane_q;

        always_ff @(posedge clk) begin
            if (clear_wr) begin
                lane_mem[ptr_reg] <= '0;
            end else if (wr_go && bus.wr_mask[gi]) begin
                lane_mem[wr_idx] <= bus.wr_data[gi*LENGTH +: LENGTH];
            end
        end

        always_ff @(posedge clk) begin
            if (rd_go) begin
                lane_q <= lane_mem[rd_idx];
            end
        end

        assign raw_q[gi*LENGTH +: LENGTH] = lane_q;
    end

    // First read stage: valid and range flag travel with the raw row.
    logic                  v1_reg;
    logic                  range1_reg;
    logic [DATA_WIDTH-1:0] data1;

    always_ff @(posedge clk) begin
        if (RST) begin
            v1_reg     <= 1'b0;
            range1_reg <= 1'b0;
        end else begin
            v1_reg <= rd_go;
            if (rd_go) begin
                range1_reg <= rd_in_range;
            end
        end
    end

    // Out-of-range reads return zero; with range1_reg reset low this also
    // gives rd_data=0 after reset without resetting the RAM output.
    assign data1 = range1_reg ? raw_q : '0;

    if (RD_LATENCY == 1) begin : g_lat1
        assign bus.rd_data  = data1;
        assign bus.rd_valid = v1_reg;
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] rd_data_reg;
        logic                  rd_valid_reg;

        always_ff @(posedge clk) begin
            if (RST) begin
                rd_data_reg  <= '0;
                rd_valid_reg <= 1'b0;
            end else begin
                rd_valid_reg <= v1_reg;
                if (v1_reg) begin
                    rd_data_reg <= data1;
                end
            end
        end

        assign bus.rd_data  = rd_data_reg;
        assign bus.rd_valid = rd_valid_reg;
    end

    assign bus.busy     = !ready;
    assign bus.addr_err = addr_err_reg;
endmodule

// File: doc/dataset_ram.md
Name: dataset_ram

Overview:
- Synchronous, clocked single-write/single-read RAM that holds the training dataset.
- One row is one data point: MAX_FEATURES feature lanes plus one y-value lane, each LENGTH bits wide.
- Successor to the tri-state, address-triggered dataset RAM:
  - separate read and write buses;
  - per-lane write mask;
  - configurable registered read latency;
  - hardware clear sequencer with busy flag;
  - out-of-range address detection.
- Sits between the dataset loader (writer) and the regression/compute datapath (reader).

Parameters:
- ADDR_WIDTH, 12, address bus width.
- MAX_FEATURES, 15, number of feature lanes per row; lane MAX_FEATURES holds y.
- LENGTH, 16, bits per lane.
- LANES, MAX_FEATURES+1, lanes per row (derived, do not override).
- DATA_WIDTH, LENGTH*LANES, row width (derived).
- DEPTH, 100, number of rows (data points); must be ≤ 2^ADDR_WIDTH.
- RD_LATENCY, 1, cycles from read request to rd_valid; legal values 1 or 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- clr  in  1  soft-clear request (single-cycle pulse).
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write row address.
- wr_mask  in  LANES  per-lane write enable; bit k selects wr_data[k*LENGTH +: LENGTH].
- wr_data  in  DATA_WIDTH  write row data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read row address.
- rd_data  out  DATA_WIDTH  read row data.
- rd_valid  out  1  single-cycle pulse; rd_data is valid this cycle.
- busy  out  1  clear sequence in progress; requests are ignored.
- addr_err  out  1  sticky flag; set by any out-of-range access.

Behaviour:
- States: CLEAR, READY.
- Reset. An edge with RST=1 produces:
  - state=CLEAR, clear pointer=0, busy=1;
  - rd_data=0, rd_valid=0, addr_err=0;
  - read pipeline flushed (in-flight reads discarded).
  - RST asserted mid-clear restarts the clear from row 0.
- CLEAR:
  - Each edge with RST=0 writes row[ptr]=0, then ptr++.
  - The edge that zeroes row DEPTH-1 moves state to READY.
  - busy falls on that same edge: DEPTH edges after RST release.
  - wr_en, rd_en and clr are ignored; no rd_valid is produced; addr_err is unchanged.
- Soft clear:
  - In READY, clr=1 moves state to CLEAR and sets ptr=0 and busy=1 on the next edge.
  - addr_err is cleared on that edge.
  - In-flight reads still complete.
  - clr has priority over a same-cycle wr_en: the write is dropped.
  - A same-cycle rd_en is still serviced and reads pre-clear data.
- Write (READY, wr_en=1, wr_addr<DEPTH):
  - On the edge, lanes with wr_mask[k]=1 are updated.
  - Unmasked lanes keep their value.
  - wr_mask=0 is a legal no-op.
- Read (READY, rd_en=1):
  - The request is sampled on edge N.
  - rd_data and rd_valid=1 are presented after edge N+RD_LATENCY-1 completes, i.e. during cycle N+RD_LATENCY.
  - Back-to-back reads give one result per cycle.
  - rd_valid=0 when there is no result.
  - rd_data holds its last value while rd_valid=0.
- Read-during-write to the same address on the same edge is read-first: the old row is returned.
- Out of range (addr ≥ DEPTH):
  - A write is ignored and memory is unchanged.
  - A read still produces rd_valid with rd_data=0.
  - Either case sets addr_err on the next edge.
  - addr_err stays set until RST or an accepted clr.
- Address wrap: none; addresses above DEPTH-1 never alias.
- Storage: mem[0:DEPTH-1], DATA_WIDTH wide. No initial file load; contents are defined only after the first clear completes.

Test Plan:
- Reset clear:
  - Preload rows 0 and 99 with A5A5 in every lane, assert RST for 1 cycle.
  - busy=1 for exactly 100 edges, then 0.
  - Reads of rows 0 and 99 return all zeros with rd_valid=1.
- Masked write:
  - Write row 7 with 0x1111 in every lane, mask=all ones.
  - Then write row 7 with 0xFFFF in every lane, mask=0x8001.
  - Read row 7: lanes 0 and 15 = FFFF; lanes 1–14 = 1111.
- Read latency:
  - With RD_LATENCY=1 and then RD_LATENCY=2, issue reads of rows 3,4,5 on consecutive cycles.
  - rd_valid rises 1 (resp. 2) cycles after the first request, stays high 3 cycles, and data appears in order.
- Read-during-write:
  - Row 9 = 0x0001 in every lane; in one cycle write 0x0002 in every lane and read row 9.
  - Returned lanes = 0001; the next read returns 0002.
- Out of range:
  - Write and then read address 100.
  - Memory is unchanged, rd_data=0, rd_valid=1, addr_err=1 and held.
  - clr clears addr_err; busy is high for 100 cycles.
- Requests while busy and reset mid-clear:
  - Pulse RST, then issue wr_en/rd_en to row 2 at cycle 10 of the clear.
  - No rd_valid, and row 2 reads zero afterwards.
  - Reassert RST at cycle 50: busy stays high for a further 100 cycles.
